regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file for the dual-issue RV32 pipeline.
- Provides NUM_RD asynchronous read ports and NUM_WR synchronous write-back ports.
- Includes a per-register busy scoreboard: decode allocates a destination; write-back releases it.
- Sits between decode (read and allocate) and write-back. x0 is hardwired to zero.

---
 rtl/regfile_mp_sb.sv | 86 ++++++++
 tb/tb_regfile_mp_sb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port RV32 register file with a busy scoreboard; x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp_sb #(
  parameter int BITSIZE = 32,
  parameter int REGSIZE = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  localparam int AW = $clog2(REGSIZE),
  localparam int CW = $clog2(REGSIZE + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*AW-1:0]      rd_addr,
  output logic [NUM_RD*BITSIZE-1:0] rd_data,
  output logic [NUM_RD-1:0]         rd_busy,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*AW-1:0]      wr_addr,
  input  logic [NUM_WR*BITSIZE-1:0] wr_data,
  input  logic                      alloc_en,
  input  logic [AW-1:0]             alloc_addr,
  output logic                      alloc_ok,
  output logic [REGSIZE-1:0]        busy_vec,
  output logic [CW-1:0]             pending_cnt
);
  logic [BITSIZE-1:0] regs_q [REGSIZE];
  logic [BITSIZE-1:0] regs_d [REGSIZE];
  logic [REGSIZE-1:0] busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               alloc_wr_hit;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    alloc_wr_hit = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*BITSIZE +: BITSIZE];
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (wr_en[j] && wr_addr[j*AW +: AW] == alloc_addr) alloc_wr_hit = 1'b1;
    end
    alloc_ok = alloc_en && (alloc_addr == '0 || !busy_q[alloc_addr] || alloc_wr_hit);
    // set after clear so a new producer overrides the retiring one
    if (alloc_ok && alloc_addr != '0) busy_d[alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;
    regs_d[0] = '0;
    cnt_d = '0;
    for (int r = 0; r < REGSIZE; r++) cnt_d = cnt_d + CW'(busy_d[r]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REGSIZE; r++) regs_q[r] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*BITSIZE +: BITSIZE] = regs_q[rd_addr[i*AW +: AW]];
      rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]) begin
          rd_data[i*BITSIZE +: BITSIZE] = wr_data[j*BITSIZE +: BITSIZE];
          rd_busy[i] = alloc_ok && alloc_addr == rd_addr[i*AW +: AW];
        end
      end
`endif
      if (rd_addr[i*AW +: AW] == '0) begin
        rd_data[i*BITSIZE +: BITSIZE] = '0;
        rd_busy[i] = 1'b0;
      end
    end
  end

  assign busy_vec    = busy_q;
  assign pending_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed vectors with hand-computed expectations for regfile_mp_sb.
module tb_regfile_mp_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        alloc_ok;
  logic [31:0] busy_vec;
  logic [5:0]  pending_cnt;
  int n_cmp = 0;
  int n_err = 0;

  regfile_mp_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .alloc_ok(alloc_ok), .busy_vec(busy_vec), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    rd_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
    wr_en = 2'b01;
    wr_addr[4:0] = 5'd5;
    wr_data[31:0] = 32'hDEAD;
    rd_addr[4:0] = 5'd5;
    tick();
    tick();
    check("reset_x5", rd_data[31:0], 32'h0);
    check("reset_busy_vec", busy_vec, 32'h0);
    check("reset_pending", 32'(pending_cnt), 32'd0);
    check("reset_rd_busy", 32'(rd_busy), 32'd0);
    alloc_en = 1'b1;
    alloc_addr = 5'd3;
    #1;
    check("reset_alloc_ok", 32'(alloc_ok), 32'd1);
    alloc_en = 1'b0;
    wr_en = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    check("post_reset_x5", rd_data[31:0], 32'h0);
    wr_en = 2'b01;
    wr_addr[4:0] = 5'd0;
    wr_data[31:0] = 32'h1234;
    tick();
    wr_en = 2'b00;
    rd_addr[4:0] = 5'd0;
    #1;
    check("x0_read", rd_data[31:0], 32'h0);
    check("x0_busy", 32'(busy_vec[0]), 32'd0);
    wr_en = 2'b11;
    wr_addr = {5'd4, 5'd3};
    wr_data = {32'h22, 32'h11};
    tick();
    wr_en = 2'b00;
    rd_addr = {5'd4, 5'd3};
    #1;
    check("dual_x3", rd_data[31:0], 32'h11);
    check("dual_x4", rd_data[63:32], 32'h22);
    wr_en = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'hBBBB, 32'hAAAA};
    tick();
    wr_en = 2'b00;
    rd_addr[4:0] = 5'd7;
    #1;
    check("collision_x7", rd_data[31:0], 32'hBBBB);
    alloc_en = 1'b1;
    alloc_addr = 5'd9;
    #1;
    check("alloc9_ok", 32'(alloc_ok), 32'd1);
    tick();
    rd_addr[4:0] = 5'd9;
    #1;
    check("alloc9_busy", 32'(busy_vec[9]), 32'd1);
    check("alloc9_pending", 32'(pending_cnt), 32'd1);
    check("realloc9_refused", 32'(alloc_ok), 32'd0);
    check("x9_rd_busy", 32'(rd_busy[0]), 32'd1);
    tick();
    check("refused_pending", 32'(pending_cnt), 32'd1);
    check("refused_busy_vec", busy_vec, 32'h0000_0200);
    alloc_en = 1'b0;
    wr_en = 2'b10;
    wr_addr[9:5] = 5'd9;
    wr_data[63:32] = 32'h55;
    tick();
    wr_en = 2'b00;
    #1;
    check("wb9_busy", 32'(busy_vec[9]), 32'd0);
    check("wb9_pending", 32'(pending_cnt), 32'd0);
    check("wb9_data", rd_data[31:0], 32'h55);
    check("wb9_rd_busy", 32'(rd_busy[0]), 32'd0);
    alloc_en = 1'b1;
    alloc_addr = 5'd9;
    tick();
    wr_en = 2'b01;
    wr_addr[4:0] = 5'd9;
    wr_data[31:0] = 32'h66;
    #1;
    check("alloc_wr_ok", 32'(alloc_ok), 32'd1);
    tick();
    wr_en = 2'b00;
    alloc_en = 1'b0;
    #1;
    check("alloc_wr_data", rd_data[31:0], 32'h66);
    check("alloc_wr_busy", 32'(busy_vec[9]), 32'd1);
    check("alloc_wr_pending", 32'(pending_cnt), 32'd1);
    alloc_en = 1'b1;
    alloc_addr = 5'd0;
    #1;
    check("alloc_x0_ok", 32'(alloc_ok), 32'd1);
    tick();
    alloc_en = 1'b0;
    #1;
    check("alloc_x0_vec", busy_vec, 32'h0000_0200);
    check("alloc_x0_pending", 32'(pending_cnt), 32'd1);
    check("alloc_off_ok", 32'(alloc_ok), 32'd0);
    wr_en = 2'b01;
    wr_addr[4:0] = 5'd12;
    wr_data[31:0] = 32'hCAFE;
    rd_addr[4:0] = 5'd12;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", rd_data[31:0], 32'hCAFE);
`else
    check("bypass_same_cycle", rd_data[31:0], 32'h0);
`endif
    check("bypass_rd_busy", 32'(rd_busy[0]), 32'd0);
    tick();
    wr_en = 2'b00;
    #1;
    check("bypass_next_cycle", rd_data[31:0], 32'hCAFE);
    alloc_en = 1'b1;
    alloc_addr = 5'd12;
    tick();
    alloc_addr = 5'd13;
    tick();
    alloc_en = 1'b0;
    #1;
    check("multi_pending", 32'(pending_cnt), 32'd3);
    check("multi_vec", busy_vec, 32'h0000_3200);
    rst = 1'b0;
    rd_addr[4:0] = 5'd9;
    #1;
    check("midreset_vec", busy_vec, 32'h0);
    check("midreset_pending", 32'(pending_cnt), 32'd0);
    check("midreset_x9", rd_data[31:0], 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("after_reset_pending", 32'(pending_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
